// File: rtl/led_pkg.sv
// led_pkg: shared FSM state codes and default resolution for the LED PWM fader
package led_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RISE = 2'd1;
   localparam logic [1:0] ST_FALL = 2'd2;
   localparam int PWM_BITS_DEF = 8;
endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED's brightness level, linear fade FSM and PWM output flop
module led_fade_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS = PWM_BITS_DEF
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                tick,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic [PWM_BITS-1:0] target,
   input  logic                fade_en,
   output logic                pwm_out,
   output logic                active
);
   logic [1:0] state, state_nxt;
   logic [PWM_BITS-1:0] level, level_nxt;
   logic up, dn;
   assign up = target > level;
   assign dn = target < level;
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= ST_IDLE;
         level   <= '0;
         pwm_out <= 1'b0;
      end else begin
         state   <= state_nxt;
         level   <= level_nxt;
         pwm_out <= level > pwm_cnt;
      end
   end
   // a step only happens when already moving in the matching direction; a reversal costs one clock
   always_comb begin
      state_nxt = state;
      level_nxt = level;
      if (!fade_en) begin
         state_nxt = ST_IDLE;
         level_nxt = target;
      end else if (!up && !dn) begin
         state_nxt = ST_IDLE;
      end else if (up && state == ST_RISE && tick) begin
         level_nxt = level + 1'b1;
         state_nxt = (level_nxt == target) ? ST_IDLE : ST_RISE;
      end else if (dn && state == ST_FALL && tick) begin
         level_nxt = level - 1'b1;
         state_nxt = (level_nxt == target) ? ST_IDLE : ST_FALL;
      end else begin
         state_nxt = up ? ST_RISE : ST_FALL;
      end
   end
   always_comb active = state != ST_IDLE;
endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: turns the counter's LED pattern into faded PWM drive for the Dock LEDs
module led_pwm_fader
   import led_pkg::*;
#(
   parameter int N_LEDS   = 4,
   parameter int PWM_BITS = PWM_BITS_DEF,
   parameter int FADE_DIV = 26_470
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic [N_LEDS-1:0]   led_in,
   input  logic [PWM_BITS-1:0] max_level,
   input  logic                fade_en,
   output logic [N_LEDS-1:0]   IO_voltage,
   output logic                busy
);
   localparam int DW = $clog2(FADE_DIV + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(FADE_DIV - 1);
   // period is 2^PWM_BITS-1 so a full-scale level stays constantly high
   localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
   logic [N_LEDS-1:0] led_q, active;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [DW-1:0] div_cnt;
   logic tick;
   assign tick = div_cnt == DIV_LAST;
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         led_q   <= '0;
         pwm_cnt <= '0;
         div_cnt <= '0;
         busy    <= 1'b0;
      end else begin
         led_q   <= led_in;
         pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         busy    <= |active;
      end
   end
   for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
      led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
         .Clock   (Clock),
         .Reset_n (Reset_n),
         .tick    (tick),
         .pwm_cnt (pwm_cnt),
         .target  (led_q[i] ? max_level : '0),
         .fade_en (fade_en),
         .pwm_out (IO_voltage[i]),
         .active  (active[i])
      );
   end
endmodule
